chan_array_stream_merge: RTL and testbench
==========================================

# chan_array_stream_merge

Parametrised multi-channel ingress buffer that takes NCH independent valid/ready streams, presented as unpacked port arrays with parameter-derived widths, and merges them into one registered output stream with round-robin arbitration. Each channel has its own DEPTH-entry FIFO and a per-channel fill level. The block sits between per-lane producers and a single shared consumer. It is the array-port, parameter-in-array generation of our lane interfaces, adding buffering, arbitration and flush.

## Interface
- NCH, default 6: number of input channels; at least 2.
- WIDTH, default 8: data width per channel.
- DEPTH, default 4: entries per channel FIFO; a power of 2 and at least 2.
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of all FIFOs and the output register.
- in_valid, input, 1 [NCH]: unpacked array; per-channel valid.
- in_data, input, [WIDTH-1:0] [NCH]: unpacked array; per-channel data.
- in_ready, output, 1 [NCH]: unpacked array; per-channel ready.
- out_valid, output, 1: output register holds data.
- out_data, output, [WIDTH-1:0]: output data.
- out_chan, output, [$clog2(NCH)-1:0]: source channel of out_data.
- out_ready, input, 1: consumer accepts.
- fill_level, output, [$clog2(DEPTH):0] [NCH]: unpacked array; entries held in each FIFO, excluding the output register.

## Operation
**Reset values:**
- out_valid=0, out_data=0, out_chan=0, every fill_level=0.
- Round-robin pointer = 0.
- in_ready: all 0 while rst_n is low. A live flop goes to 1 on the first clk edge after rst_n rises, and in_ready is gated by it.

**Push:**
- in_ready[i] = live && !flush && fill_level[i] < DEPTH.
- A push happens when in_valid[i] && in_ready[i]. The word is written at wr_ptr[i] and the pointer advances modulo DEPTH.
- There is no bypass from a full FIFO: in_ready depends only on the current count, even when a pop of the same channel occurs that cycle.

**Load / arbitration:**
- The output register is loadable when !out_valid || out_ready.
- When loadable, the arbiter searches channels rr, rr+1, …, NCH-1, 0, … for the first non-empty FIFO.
- On a grant to channel g:
  - pop the head of g into out_data and set out_chan=g, out_valid=1;
  - rr becomes (g+1) mod NCH.
- When loadable and every FIFO is empty, out_valid becomes 0 and out_data/out_chan hold their last values.

**Simultaneous push and pop on the same channel:** fill_level is unchanged and both pointers advance.

**Flush (has priority over everything):**
- All counts and pointers go to 0, out_valid goes to 0, rr goes to 0.
- Pushes in the flush cycle are dropped; in_ready is 0 during flush.
- out_ready in the flush cycle is ignored.

**Widths:**
- fill_level saturates structurally at DEPTH.
- Pointers are $clog2(DEPTH) bits with natural wrap.
- out_chan is a plain binary channel index.

## Timing
- Minimum latency: a word pushed at edge t can appear on out_valid/out_data right after edge t+1. That is 2 cycles from in_valid to out_valid.
- Throughput is one word per cycle on the output when out_ready is held high and any FIFO is non-empty.
- Per-channel throughput is one word per cycle only while it is the sole active channel.
- fill_level and in_ready update the cycle after a push or pop edge.
- Handshake rule: out_data and out_chan must stay stable while out_valid && !out_ready.
- Reset assertion mid-transfer clears state immediately (asynchronously). In-flight words are lost and out_valid drops with no clock edge needed.

## Test plan
- **Reset / live:** hold rst_n=0 for 3 cycles with all in_valid=1.
  - During reset: in_ready all 0, out_valid 0.
  - One edge after release: in_ready all 1, fill_level all 0.
- **Single channel latency:** push 0x5A on channel 3 at edge t with out_ready=1.
  - out_valid=1, out_data=0x5A, out_chan=3 after edge t+1.
  - fill_level[3] back to 0.
- **Fill and back-pressure:** out_ready=0, push 5 words on channel 0 with DEPTH=4.
  - One word sits in the output register and 4 fill the FIFO.
  - fill_level[0]=4 and in_ready[0]=0; the 6th word is not accepted.
  - Raise out_ready: words drain in order with no loss.
- **Round-robin fairness:** preload 2 words each in channels 0, 2 and 5, then out_ready=1.
  - out_chan sequence is 0,2,5,0,2,5.
- **Concurrent push/pop:** channel 1 at fill_level 2; push and pop channel 1 in the same cycle.
  - fill_level stays 2 and data order is preserved.
- **Flush mid-stream:** pulse flush with out_valid=1, channels non-empty and in_valid=1.
  - Next cycle: out_valid=0, all fill_level=0, rr=0.
  - The flushed pushes do not appear on the output.

Source files
------------

// File: rtl/chan_array_stream_merge.sv
// chan_array_stream_merge
// Merges NCH independent valid/ready ingress streams into one registered
// output stream. Each channel owns a DEPTH-entry FIFO; a round-robin arbiter
// picks the next non-empty channel whenever the output register can load.
// A synchronous flush clears every FIFO, the output register and the arbiter.
module chan_array_stream_merge #(
   parameter int NCH   = 6,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid   [NCH],
   input  logic [WIDTH-1:0]           in_data    [NCH],
   output logic                       in_ready   [NCH],
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(NCH)-1:0]     out_chan,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fill_level [NCH]
);

   localparam int CW = $clog2(NCH);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   // Ingress becomes live one edge after reset release
   logic                 live_q;

   // Per-channel storage and bookkeeping
   logic [WIDTH-1:0]     mem_q     [NCH][DEPTH];
   logic [PW-1:0]        wr_ptr_q  [NCH];
   logic [PW-1:0]        wr_ptr_d  [NCH];
   logic [PW-1:0]        rd_ptr_q  [NCH];
   logic [PW-1:0]        rd_ptr_d  [NCH];
   logic [LW-1:0]        cnt_q     [NCH];
   logic [LW-1:0]        cnt_d     [NCH];
   logic                 push      [NCH];
   logic                 pop       [NCH];

   // Arbitration and output register
   logic                 load_en;
   logic                 grant_vld;
   logic [CW-1:0]        grant_idx;
   logic [WIDTH-1:0]     head_data;
   logic [CW-1:0]        rr_q;
   logic [CW-1:0]        rr_d;
   logic                 out_valid_q;
   logic                 out_valid_d;
   logic [WIDTH-1:0]     out_data_q;
   logic [WIDTH-1:0]     out_data_d;
   logic [CW-1:0]        out_chan_q;
   logic [CW-1:0]        out_chan_d;

   // The output register may take a new word when empty or being drained
   assign load_en = !out_valid_q || out_ready;

   // Accept a word only into a FIFO that is not full right now; a same-cycle
   // pop never opens a slot early, so in_ready depends only on the count
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         in_ready[i] = live_q && !flush && (cnt_q[i] < LW'(DEPTH));
         push[i]     = in_valid[i] && in_ready[i];
      end
   end

   // Round-robin search starting at rr for the first non-empty FIFO
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (!grant_vld && (cnt_q[idx] != '0)) begin
            grant_vld = 1'b1;
            grant_idx = CW'(idx);
         end
      end
   end

   // Pop strobe for the granted channel and its head word
   always_comb begin
      head_data = '0;
      for (int i = 0; i < NCH; i++) begin
         pop[i] = load_en && grant_vld && !flush && (grant_idx == CW'(i));
         if (grant_idx == CW'(i)) begin
            head_data = mem_q[i][rd_ptr_q[i]];
         end
      end
   end

   // Per-channel pointer and count next state; flush zeroes everything
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         cnt_d[i]    = cnt_q[i];
         if (flush) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            cnt_d[i]    = '0;
         end else begin
            if (push[i]) begin
               wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
               rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            case ({push[i], pop[i]})
               2'b10:   cnt_d[i] = cnt_q[i] + LW'(1);
               2'b01:   cnt_d[i] = cnt_q[i] - LW'(1);
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end

   // Output register and arbiter pointer next state
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_d        = rr_q;
      if (flush) begin
         out_valid_d = 1'b0;
         rr_d        = '0;
      end else if (load_en) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_data_d = head_data;
            out_chan_d = grant_idx;
            rr_d       = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
         end
      end
   end

   // Control state: liveness, pointers, counts, output register, arbiter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_q        <= '0;
         for (int i = 0; i < NCH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         live_q      <= 1'b1;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_q        <= rr_d;
         for (int i = 0; i < NCH; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   // FIFO storage write; payload needs no reset since counts gate its use
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= in_data[i];
         end
      end
   end

   // Drive outputs from registered state
   always_comb begin
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_chan  = out_chan_q;
      for (int i = 0; i < NCH; i++) begin
         fill_level[i] = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_chan_array_stream_merge.sv
// Directed testbench for chan_array_stream_merge (NCH=6, WIDTH=8, DEPTH=4).
module tb_chan_array_stream_merge;

   localparam int NCH   = 6;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid   [NCH];
   logic [WIDTH-1:0] in_data    [NCH];
   logic             in_ready   [NCH];
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       out_chan;
   logic             out_ready;
   logic [2:0]       fill_level [NCH];

   int vectors     = 0;
   int miscompares = 0;

   chan_array_stream_merge #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .out_ready  (out_ready),
      .fill_level (fill_level)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < NCH; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = '0;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         in_valid[i] = 1'b1;
         in_data[i]  = 8'(i + 1);
      end
      repeat (3) begin
         tick();
         for (int i = 0; i < NCH; i++) begin
            vectors++;
            if (in_ready[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_in_ready[%0d]: got %b expected 0", i, in_ready[i]);
            end
         end
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
         end
      end
      vectors++;
      if (out_data !== 8'h00 || out_chan !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_out_regs: got data %h chan %0d expected 00 0", out_data, out_chan);
      end
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < NCH; i++) begin
         vectors++;
         if (in_ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL live_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
         end
         vectors++;
         if (fill_level[i] !== 3'd0) begin
            miscompares++;
            $display("FAIL live_fill[%0d]: got %0d expected 0", i, fill_level[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_single_latency();
      out_ready   = 1'b1;
      in_valid[3] = 1'b1;
      in_data[3]  = 8'h5A;
      tick();
      idle_inputs();
      vectors++;
      if (fill_level[3] !== 3'd1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lat_after_push: got fill %0d valid %b expected 1 0", fill_level[3], out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 3'd3) begin
         miscompares++;
         $display("FAIL lat_output: got v%b d%h c%0d expected v1 d5a c3", out_valid, out_data, out_chan);
      end
      vectors++;
      if (fill_level[3] !== 3'd0) begin
         miscompares++;
         $display("FAIL lat_fill: got %0d expected 0", fill_level[3]);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lat_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_fill_backpressure();
      int exp_fill [6];
      logic exp_ov [6];
      exp_fill  = '{1, 1, 2, 3, 4, 4};
      exp_ov    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 8'(8'hA0 + k);
         tick();
         vectors++;
         if (fill_level[0] !== 3'(exp_fill[k]) || out_valid !== exp_ov[k]) begin
            miscompares++;
            $display("FAIL bp_fill[%0d]: got fill %0d valid %b expected %0d %b",
                     k, fill_level[0], out_valid, exp_fill[k], exp_ov[k]);
         end
         vectors++;
         if (in_ready[0] !== (exp_fill[k] < DEPTH)) begin
            miscompares++;
            $display("FAIL bp_ready[%0d]: got %b expected %b", k, in_ready[0], exp_fill[k] < DEPTH);
         end
      end
      vectors++;
      if (out_data !== 8'hA0 || out_chan !== 3'd0) begin
         miscompares++;
         $display("FAIL bp_hold: got d%h c%0d expected a0 0", out_data, out_chan);
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + k) || fill_level[0] !== 3'(4 - k)) begin
            miscompares++;
            $display("FAIL bp_drain[%0d]: got v%b d%h fill %0d expected v1 d%h fill %0d",
                     k, out_valid, out_data, fill_level[0], 8'(8'hA0 + k), 4 - k);
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_round_robin();
      int exp_ch [5];
      int exp_d  [5];
      exp_ch = '{2, 5, 0, 2, 5};
      exp_d  = '{8'h20, 8'h50, 8'h01, 8'h21, 8'h51};
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_valid[0] = 1'b1; in_data[0] = 8'(8'h00 + w);
         in_valid[2] = 1'b1; in_data[2] = 8'(8'h20 + w);
         in_valid[5] = 1'b1; in_data[5] = 8'(8'h50 + w);
         tick();
      end
      idle_inputs();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL rr_first: got v%b c%0d d%h expected v1 c0 d00", out_valid, out_chan, out_data);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_chan !== 3'(exp_ch[k]) || out_data !== 8'(exp_d[k])) begin
            miscompares++;
            $display("FAIL rr_seq[%0d]: got v%b c%0d d%h expected v1 c%0d d%h",
                     k, out_valid, out_chan, out_data, exp_ch[k], 8'(exp_d[k]));
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_concurrent();
      out_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         in_valid[1] = 1'b1;
         in_data[1]  = 8'(8'hB0 + w);
         tick();
      end
      vectors++;
      if (fill_level[1] !== 3'd2 || out_data !== 8'hB0 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL cc_setup: got fill %0d d%h v%b expected 2 b0 1", fill_level[1], out_data, out_valid);
      end
      in_data[1] = 8'hB3;
      out_ready  = 1'b1;
      tick();
      idle_inputs();
      vectors++;
      if (fill_level[1] !== 3'd2 || out_data !== 8'hB1 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL cc_pushpop: got fill %0d d%h v%b expected 2 b1 1", fill_level[1], out_data, out_valid);
      end
      for (int k = 2; k < 4; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== 8'(8'hB0 + k) || fill_level[1] !== 3'(3 - k)) begin
            miscompares++;
            $display("FAIL cc_order[%0d]: got v%b d%h fill %0d expected v1 d%h fill %0d",
                     k, out_valid, out_data, fill_level[1], 8'(8'hB0 + k), 3 - k);
         end
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL cc_empty: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_valid[2] = 1'b1; in_data[2] = 8'(8'hC0 + w);
         in_valid[4] = 1'b1; in_data[4] = 8'(8'hD0 + w);
         tick();
      end
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 3'd2 || fill_level[4] !== 3'd2) begin
         miscompares++;
         $display("FAIL fl_setup: got v%b c%0d fill4 %0d expected 1 2 2", out_valid, out_chan, fill_level[4]);
      end
      in_data[2] = 8'hC2;
      in_data[4] = 8'hD2;
      out_ready  = 1'b1;
      flush      = 1'b1;
      #1;
      for (int i = 0; i < NCH; i++) begin
         vectors++;
         if (in_ready[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL fl_ready[%0d]: got %b expected 0", i, in_ready[i]);
         end
      end
      tick();
      flush = 1'b0;
      idle_inputs();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fl_out_valid: got %b expected 0", out_valid);
      end
      for (int i = 0; i < NCH; i++) begin
         vectors++;
         if (fill_level[i] !== 3'd0) begin
            miscompares++;
            $display("FAIL fl_fill[%0d]: got %0d expected 0", i, fill_level[i]);
         end
      end
      in_valid[1] = 1'b1; in_data[1] = 8'h11;
      in_valid[5] = 1'b1; in_data[5] = 8'h55;
      tick();
      idle_inputs();
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 3'd1 || out_data !== 8'h11) begin
         miscompares++;
         $display("FAIL fl_rr_first: got v%b c%0d d%h expected v1 c1 d11", out_valid, out_chan, out_data);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 3'd5 || out_data !== 8'h55) begin
         miscompares++;
         $display("FAIL fl_rr_second: got v%b c%0d d%h expected v1 c5 d55", out_valid, out_chan, out_data);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fl_no_stale: got v%b d%h expected v0", out_valid, out_data);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 8'(8'h77 + w);
         tick();
      end
      idle_inputs();
      vectors++;
      if (out_valid !== 1'b1 || fill_level[0] !== 3'd1) begin
         miscompares++;
         $display("FAIL ar_setup: got v%b fill %0d expected 1 1", out_valid, fill_level[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || fill_level[0] !== 3'd0 || in_ready[0] !== 1'b0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL ar_clear: got v%b fill %0d rdy %b d%h expected 0 0 0 00",
                  out_valid, fill_level[0], in_ready[0], out_data);
      end
      #1;
      rst_n = 1'b1;
      tick();
      vectors++;
      if (in_ready[0] !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ar_relive: got rdy %b v%b expected 1 0", in_ready[0], out_valid);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_latency();
      test_fill_backpressure();
      test_round_robin();
      test_concurrent();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected completion within time limit");
      $fatal(1, "timeout");
   end

endmodule
